// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcodes, ALU function codes and FSM states shared by cpu_seq_ctrl
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_AND    = 2'd2;
  localparam logic [1:0] ALU_PASS_A = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OPRD,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_e;

  // Opcodes 9..E have no meaning; they raise illegal and then act as NOP.
  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multicycle fetch/decode/execute sequencer (optional CPU_SEQ_SINGLE_STEP_EN adds step input)
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Load_A,
  output logic              Load_B,
  output logic [1:0]        alu_op,
  output logic              alu_latch,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              halted,
  output logic              illegal
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ir_q;
  logic              req_q;
  logic              we_q;
  logic [1:0]        alu_op_q;
  logic              alu_latch_q;
  logic              halted_q;
  logic              illegal_q;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] ir_addr;
  logic [ADDR_W-1:0] decode_pc;
  logic              ack_seen;
  logic              fetch_go;

  // Single-step builds park in FETCH with no request until step is seen;
  // otherwise every return to FETCH pre-arms the next instruction request.
`ifdef CPU_SEQ_SINGLE_STEP_EN
  localparam logic AUTO_FETCH = 1'b0;
  assign fetch_go = step;
`else
  localparam logic AUTO_FETCH = 1'b1;
  assign fetch_go = 1'b1;
`endif

  assign opcode   = ir_q[DATA_W-1 -: 4];
  assign ir_addr  = ir_q[ADDR_W-1:0];
  assign ack_seen = req_q & mem_ack;

  // Branch target resolution: JMP always, JZ on the zero flag seen in DECODE.
  always_comb begin
    decode_pc = pc_q;
    if ((opcode == OP_JMP) || ((opcode == OP_JZ) && alu_zero)) begin
      decode_pc = ir_addr;
    end
  end

  // Operand strobes track the ack so the register captures mem_rdata at this edge;
  // a reset cycle suppresses them even if an ack is still pending.
  assign Load_A = (state_q == S_OPRD) && ack_seen && !reset && (opcode == OP_LDA);
  assign Load_B = (state_q == S_OPRD) && ack_seen && !reset && (opcode == OP_LDB);

  // Sequencer: state, PC/IR and all registered bus/ALU controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      alu_op_q    <= ALU_ADD;
      alu_latch_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      alu_latch_q <= 1'b0;
      illegal_q   <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            if (fetch_go) begin
              req_q  <= 1'b1;
              we_q   <= 1'b0;
              addr_q <= pc_q;
            end
          end else if (mem_ack) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + ADDR_W'(1);
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LDA, OP_LDB: begin
              state_q <= S_OPRD;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= ir_addr;
            end
            OP_ADD: begin
              state_q     <= S_EXEC;
              alu_op_q    <= ALU_ADD;
              alu_latch_q <= 1'b1;
            end
            OP_SUB: begin
              state_q     <= S_EXEC;
              alu_op_q    <= ALU_SUB;
              alu_latch_q <= 1'b1;
            end
            OP_AND: begin
              state_q     <= S_EXEC;
              alu_op_q    <= ALU_AND;
              alu_latch_q <= 1'b1;
            end
            OP_STA: begin
              state_q  <= S_STORE;
              req_q    <= 1'b1;
              we_q     <= 1'b1;
              addr_q   <= ir_addr;
              alu_op_q <= ALU_PASS_A;
            end
            OP_HLT: begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
            default: begin
              // NOP, JMP, JZ and illegal opcodes all go straight back to FETCH.
              illegal_q <= is_illegal(opcode);
              pc_q      <= decode_pc;
              state_q   <= S_FETCH;
              req_q     <= AUTO_FETCH;
              we_q      <= 1'b0;
              addr_q    <= decode_pc;
            end
          endcase
        end
        S_OPRD, S_STORE: begin
          if (ack_seen) begin
            state_q <= S_FETCH;
            req_q   <= AUTO_FETCH;
            we_q    <= 1'b0;
            addr_q  <= pc_q;
          end
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          req_q   <= AUTO_FETCH;
          we_q    <= 1'b0;
          addr_q  <= pc_q;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign alu_op    = alu_op_q;
  assign alu_latch = alu_latch_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - self-checking bench for cpu_seq_ctrl with an instruction-level reference model
module tb_cpu_seq_ctrl;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          step = 1'b1;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          alu_zero = 1'b0;
  logic          mem_req, mem_we, Load_A, Load_B, alu_latch, halted, illegal;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] ir;
  logic [1:0]    alu_op;

  cpu_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'h000)) dut (
    .clk(clk),
    .reset(reset),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .Load_A(Load_A),
    .Load_B(Load_B),
    .alu_op(alu_op),
    .alu_latch(alu_latch),
    .alu_zero(alu_zero),
    .pc(pc),
    .ir(ir),
    .halted(halted),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:4095];
  int ack_mode = 0;  // 0 random-latency responder, 1 ack tied high, 2 driven by the test
  int min_dly = 0, max_dly = 0, wait_cnt = 0, cur_dly = 0;

  logic [12:0] bus_log[$], exp_bus[$];
  int          bus_cyc[$];
  logic [16:0] load_log[$], exp_load[$];
  logic [1:0]  latch_log[$], exp_latch[$];
  int ill_cnt, exp_ill, cyc;
  int hold_viol, both_viol, overlap_viol, sta_op_viol, halt_req_viol, strobe_viol;
  bit prev_pend;
  logic [12:0] prev_bus;
  bit model_halt, timed_out;
  int bus_diff, load_diff, latch_diff;

  // Memory responder: drives ack/rdata just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (ack_mode == 1) begin
      mem_ack = 1'b1;
      mem_rdata = mem[mem_addr];
    end else if (ack_mode == 0) begin
      if (mem_req === 1'b1 && !reset) begin
        if (wait_cnt >= cur_dly) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          wait_cnt = 0;
          cur_dly = $urandom_range(max_dly, min_dly);
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
          wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end
  end

  // Bus/strobe monitor on the falling edge: logs completed transfers and protocol violations.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (prev_pend && !(mem_req === 1'b1 && {mem_we, mem_addr} === prev_bus)) hold_viol++;
      if (Load_A && Load_B) both_viol++;
      if (alu_latch && (Load_A || Load_B)) overlap_viol++;
      if (mem_req && mem_we && alu_op !== 2'd3) sta_op_viol++;
      if (halted && mem_req) halt_req_viol++;
      if ((Load_A || Load_B) && !(mem_req && mem_ack)) strobe_viol++;
      if (mem_req && mem_ack) begin
        bus_log.push_back({mem_we, mem_addr});
        bus_cyc.push_back(cyc);
      end
      if (Load_A) load_log.push_back({1'b0, mem_rdata});
      if (Load_B) load_log.push_back({1'b1, mem_rdata});
      if (alu_latch) latch_log.push_back(alu_op);
      if (illegal) ill_cnt++;
      prev_pend = mem_req && !mem_ack;
      prev_bus = {mem_we, mem_addr};
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic fill_mem(input logic [15:0] v);
    foreach (mem[i]) mem[i] = v;
  endtask

  task automatic do_reset(input int mode, input int dmin, input int dmax);
    @(negedge clk);
    reset = 1'b1;
    ack_mode = mode;
    min_dly = dmin;
    max_dly = dmax;
    wait_cnt = 0;
    cur_dly = $urandom_range(dmax, dmin);
    repeat (2) @(negedge clk);
    bus_log.delete(); bus_cyc.delete(); load_log.delete(); latch_log.delete();
    ill_cnt = 0; hold_viol = 0; both_viol = 0; overlap_viol = 0;
    sta_op_viol = 0; halt_req_viol = 0; strobe_viol = 0;
    reset = 1'b0;
  endtask

  // Instruction-level model: walks the program and lists the expected bus transfers,
  // operand loads, ALU latches and illegal pulses.
  task automatic model_run(input int max_instr);
    logic [11:0] mpc, a;
    logic [15:0] ins;
    logic [3:0]  op;
    exp_bus.delete(); exp_load.delete(); exp_latch.delete();
    exp_ill = 0;
    model_halt = 1'b0;
    mpc = 12'h000;
    for (int n = 0; n < max_instr && !model_halt; n++) begin
      exp_bus.push_back({1'b0, mpc});
      ins = mem[mpc];
      mpc = mpc + 12'd1;
      op = ins[15:12];
      a = ins[11:0];
      case (op)
        4'h0: ;
        4'h1: begin exp_bus.push_back({1'b0, a}); exp_load.push_back({1'b0, mem[a]}); end
        4'h2: begin exp_bus.push_back({1'b0, a}); exp_load.push_back({1'b1, mem[a]}); end
        4'h3, 4'h4, 4'h5: exp_latch.push_back(2'(op - 4'h3));
        4'h6: exp_bus.push_back({1'b1, a});
        4'h7: mpc = a;
        4'h8: if (alu_zero) mpc = a;
        4'hF: model_halt = 1'b1;
        default: exp_ill++;
      endcase
    end
  endtask

  // Runs the program in mem from reset and tallies differences against the model.
  task automatic run_program(input int max_instr, input int dmin, input int dmax);
    model_run(max_instr);
    do_reset(0, dmin, dmax);
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (model_halt ? (halted === 1'b1) : (bus_log.size() >= exp_bus.size())) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (model_halt) repeat (6) @(negedge clk);
    bus_diff = 0; load_diff = 0; latch_diff = 0;
    if (bus_log.size() < exp_bus.size()) bus_diff++;
    if (model_halt && bus_log.size() != exp_bus.size()) bus_diff++;
    foreach (exp_bus[i]) if (i < bus_log.size() && bus_log[i] !== exp_bus[i]) bus_diff++;
    if (model_halt) begin
      if (load_log.size() != exp_load.size()) load_diff++;
      foreach (exp_load[i]) if (i < load_log.size() && load_log[i] !== exp_load[i]) load_diff++;
      if (latch_log.size() != exp_latch.size()) latch_diff++;
      foreach (exp_latch[i]) if (i < latch_log.size() && latch_log[i] !== exp_latch[i]) latch_diff++;
    end
  endtask

  task automatic test_reset();
    fill_mem(16'hF000);
    mem[0] = 16'h7005;
    alu_zero = 1'b0;
    do_reset(1, 0, 0);
    checks++;
    if ({mem_req, mem_we, Load_A, Load_B, alu_latch, halted, illegal} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000000", {mem_req, mem_we, Load_A, Load_B, alu_latch, halted, illegal});
    end
    checks++;
    if (pc !== 12'h000 || ir !== 16'h0000 || alu_op !== 2'd0) begin
      failures++;
      $display("FAIL reset_regs got pc=%h ir=%h alu_op=%0d exp pc=000 ir=0000 alu_op=0", pc, ir, alu_op);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h000) begin
      failures++;
      $display("FAIL first_req got req=%b we=%b addr=%h exp req=1 we=0 addr=000", mem_req, mem_we, mem_addr);
    end
    checks++;
    if (ir !== 16'h0000) begin
      failures++;
      $display("FAIL ack_without_req got ir=%h exp=0000", ir);
    end
    @(negedge clk);
    checks++;
    if (pc !== 12'h001 || ir !== 16'h7005) begin
      failures++;
      $display("FAIL first_fetch got pc=%h ir=%h exp pc=001 ir=7005", pc, ir);
    end
  endtask

  task automatic test_load_ops();
    logic [16:0] got;
    fill_mem(16'hF000);
    mem[0] = 16'h1010; mem[1] = 16'h2011; mem[2] = 16'hF000;
    mem[12'h010] = 16'h1234; mem[12'h011] = 16'($urandom);
    alu_zero = 1'b0;
    run_program(50, 0, 0);
    checks++;
    if (timed_out || bus_diff !== 0 || load_diff !== 0) begin
      failures++;
      $display("FAIL load_ops got timeout=%0d bus_diffs=%0d load_diffs=%0d exp 0/0/0", timed_out, bus_diff, load_diff);
    end
    got = (load_log.size() > 0) ? load_log[0] : 17'h1FFFF;
    checks++;
    if (got !== {1'b0, 16'h1234}) begin
      failures++;
      $display("FAIL load_a_data got=%h exp=%h", got, {1'b0, 16'h1234});
    end
    checks++;
    if (both_viol !== 0 || strobe_viol !== 0) begin
      failures++;
      $display("FAIL load_exclusive got both=%0d stray=%0d exp 0/0", both_viol, strobe_viol);
    end
  endtask

  task automatic test_alu_store();
    fill_mem(16'hF000);
    mem[0] = 16'h3000; mem[1] = 16'h4000; mem[2] = 16'h5000; mem[3] = 16'h6020; mem[4] = 16'hF000;
    alu_zero = 1'b0;
    run_program(50, 0, 0);
    checks++;
    if (timed_out || latch_diff !== 0 || bus_diff !== 0) begin
      failures++;
      $display("FAIL alu_store got timeout=%0d latch_diffs=%0d bus_diffs=%0d exp 0/0/0", timed_out, latch_diff, bus_diff);
    end
    checks++;
    if (sta_op_viol !== 0 || overlap_viol !== 0) begin
      failures++;
      $display("FAIL store_alu_op got bad_store_op=%0d latch_overlap=%0d exp 0/0", sta_op_viol, overlap_viol);
    end
  endtask

  task automatic test_wait_states();
    fill_mem(16'hF000);
    mem[0] = 16'h1010; mem[1] = 16'h6030; mem[2] = 16'h2011; mem[3] = 16'hF000;
    mem[12'h010] = 16'hBEEF; mem[12'h011] = 16'h0F0F;
    alu_zero = 1'b0;
    run_program(50, 3, 3);
    checks++;
    if (timed_out || hold_viol !== 0 || bus_diff !== 0 || load_diff !== 0) begin
      failures++;
      $display("FAIL wait3 got timeout=%0d hold=%0d bus_diffs=%0d load_diffs=%0d exp 0/0/0/0", timed_out, hold_viol, bus_diff, load_diff);
    end
    run_program(50, 0, 5);
    checks++;
    if (timed_out || hold_viol !== 0 || bus_diff !== 0 || load_diff !== 0 || strobe_viol !== 0) begin
      failures++;
      $display("FAIL wait_rand got timeout=%0d hold=%0d bus_diffs=%0d load_diffs=%0d stray=%0d exp all 0", timed_out, hold_viol, bus_diff, load_diff, strobe_viol);
    end
  endtask

  task automatic test_jumps();
    logic [12:0] got;
    fill_mem(16'hF000);
    mem[0] = 16'h8100;
    alu_zero = 1'b1;
    run_program(20, 0, 1);
    got = (bus_log.size() > 1) ? bus_log[1] : 13'h1FFF;
    checks++;
    if (timed_out || got !== {1'b0, 12'h100} || bus_diff !== 0) begin
      failures++;
      $display("FAIL jz_taken got timeout=%0d fetch=%h exp fetch=%h", timed_out, got, {1'b0, 12'h100});
    end
    alu_zero = 1'b0;
    run_program(20, 0, 1);
    got = (bus_log.size() > 1) ? bus_log[1] : 13'h1FFF;
    checks++;
    if (timed_out || got !== {1'b0, 12'h001} || bus_diff !== 0) begin
      failures++;
      $display("FAIL jz_not_taken got timeout=%0d fetch=%h exp fetch=%h", timed_out, got, {1'b0, 12'h001});
    end
    mem[0] = 16'h7FFF; mem[12'hFFF] = 16'h0000;
    run_program(3, 0, 0);
    got = (bus_log.size() > 2) ? bus_log[2] : 13'h1FFF;
    checks++;
    if (timed_out || got !== {1'b0, 12'h000} || bus_diff !== 0) begin
      failures++;
      $display("FAIL pc_wrap got timeout=%0d fetch=%h exp fetch=%h", timed_out, got, {1'b0, 12'h000});
    end
  endtask

  task automatic test_illegal_halt();
    fill_mem(16'hF000);
    mem[0] = 16'hA000; mem[1] = 16'h0000; mem[2] = 16'hF000;
    alu_zero = 1'b0;
    run_program(20, 0, 2);
    checks++;
    if (timed_out || ill_cnt !== 1 || bus_diff !== 0) begin
      failures++;
      $display("FAIL illegal got timeout=%0d pulses=%0d bus_diffs=%0d exp 0/1/0", timed_out, ill_cnt, bus_diff);
    end
    checks++;
    if (halted !== 1'b1 || halt_req_viol !== 0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL halt got halted=%b req_in_halt=%0d req=%b exp 1/0/0", halted, halt_req_viol, mem_req);
    end
  endtask

  task automatic test_back_to_back();
    int fidx [7] = '{0, 1, 3, 4, 6, 7, 8};
    int gaps [6] = '{2, 3, 3, 3, 2, 2};
    int got;
    fill_mem(16'hF000);
    mem[0] = 16'h0000; mem[1] = 16'h1010; mem[2] = 16'h3000; mem[3] = 16'h6020;
    mem[4] = 16'h7005; mem[5] = 16'h8006; mem[6] = 16'hF000;
    alu_zero = 1'b0;
    run_program(20, 0, 0);
    checks++;
    if (timed_out || bus_log.size() != 9) begin
      failures++;
      $display("FAIL latency_setup got timeout=%0d transfers=%0d exp 0/9", timed_out, bus_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        got = bus_cyc[fidx[i+1]] - bus_cyc[fidx[i]];
        checks++;
        if (got !== gaps[i]) begin
          failures++;
          $display("FAIL latency_instr%0d got=%0d exp=%0d", i, got, gaps[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_oprd();
    bit found = 1'b0;
    fill_mem(16'hF000);
    mem[0] = 16'h1010; mem[12'h010] = 16'h1234;
    alu_zero = 1'b0;
    do_reset(0, 2, 2);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 12'h010) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_oprd_reach got=not_reached exp=oprd_request");
    end
    ack_mode = 2;
    mem_ack = 1'b1;
    mem_rdata = 16'h1234;
    reset = 1'b1;
    #1;
    checks++;
    if (Load_A !== 1'b0 || Load_B !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack_strobe got A=%b B=%b exp 0/0", Load_A, Load_B);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || pc !== 12'h000 || ir !== 16'h0000 || Load_A !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_oprd got req=%b pc=%h ir=%h A=%b exp 0/000/0000/0", mem_req, pc, ir, Load_A);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_random();
    int k;
    logic [3:0] op;
    logic [11:0] a;
    for (int it = 0; it < 6; it++) begin
      fill_mem(16'hF000);
      for (int j = 12'h200; j < 12'h300; j++) mem[j] = 16'($urandom);
      alu_zero = 1'($urandom_range(1, 0));
      for (int i = 0; i < 12; i++) begin
        k = $urandom_range(9, 0);
        op = (k == 9) ? 4'($urandom_range(14, 9)) : 4'(k);
        a = 12'h200 + 12'($urandom_range(255, 0));
        if (op == 4'h7 || op == 4'h8) a = 12'($urandom_range(12, i + 1));
        mem[i] = {op, a};
      end
      mem[12] = 16'hF000;
      run_program(100, 0, 3);
      checks++;
      if (timed_out || bus_diff !== 0 || load_diff !== 0 || latch_diff !== 0 || ill_cnt !== exp_ill) begin
        failures++;
        $display("FAIL random%0d got timeout=%0d bus=%0d load=%0d latch=%0d ill=%0d exp 0/0/0/0 ill=%0d", it, timed_out, bus_diff, load_diff, latch_diff, ill_cnt, exp_ill);
      end
      checks++;
      if (hold_viol + both_viol + overlap_viol + sta_op_viol + halt_req_viol + strobe_viol !== 0) begin
        failures++;
        $display("FAIL random%0d_protocol got hold=%0d both=%0d overlap=%0d staop=%0d haltreq=%0d stray=%0d exp all 0", it, hold_viol, both_viol, overlap_viol, sta_op_viol, halt_req_viol, strobe_viol);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_ops();
    test_alu_store();
    test_wait_states();
    test_jumps();
    test_illegal_halt();
    test_back_to_back();
    test_reset_mid_oprd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
